// File: rtl/pc_stack_gen_pkg.sv
// pc_stack_gen_pkg: shared encodings for the nibble-serial PC and its return stack.
package pc_stack_gen_pkg;
  localparam int NIB_W = 4;
  localparam logic [1:0] PC_FROM_DATA = 2'd0;
  localparam logic [1:0] PC_FROM_REG = 2'd1;
  typedef enum logic [1:0] {STACK_NOP, STACK_PUSH, STACK_POP, STACK_CLR} stack_op_e;
endpackage

// File: rtl/pc_stack_gen_return_stack.sv
// return_stack: ring-buffer return-address stack with saturating count and sticky flags.
module return_stack #(
  parameter int DEPTH = 3,
  parameter int W = 12
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         clear,
  input  logic [W-1:0]                 push_data,
  output logic [W-1:0]                 top,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow,
  output logic                         underflow
);
  localparam int SP_W = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  logic [W-1:0] mem [DEPTH];
  logic [SP_W-1:0] sp, sp_inc, sp_dec;
  logic full, empty;
  assign full = count == CNT_W'(DEPTH);
  assign empty = count == '0;
  assign sp_inc = sp == SP_W'(DEPTH - 1) ? '0 : sp + SP_W'(1);
  assign sp_dec = sp == '0 ? SP_W'(DEPTH - 1) : sp - SP_W'(1);
  assign top = mem[sp_dec];
  // Entries carry no reset; only sp/count decide which are meaningful.
  always_ff @(posedge clock) if (push) mem[sp] <= push_data;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      sp <= '0;
      count <= '0;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else if (push) begin
      sp <= sp_inc;
      count <= full ? count : count + CNT_W'(1);
      overflow <= overflow | full;
    end else if (pop) begin
      if (!empty) begin
        sp <= sp_dec;
        count <= count - CNT_W'(1);
      end else underflow <= 1'b1;
    end else if (clear) begin
      overflow <= 1'b0;
      underflow <= 1'b0;
    end
endmodule

// File: rtl/pc_stack_gen.sv
// pc_stack_gen: nibble-serial program counter with rippled increment, loads and a return stack.
module pc_stack_gen
  import pc_stack_gen_pkg::*;
#(
  parameter int PC_NIBBLES = 3,
  parameter int STACK_DEPTH = 3,
  parameter int CYCLE_W = 3
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               halt,
  input  logic [CYCLE_W-1:0]                 cycle,
  input  logic [1:0]                         stack_op,
  input  logic [NIB_W-1:0]                   regval,
  input  logic [NIB_W-1:0]                   data,
  input  logic [1:0]                         pc_next_sel,
  input  logic [PC_NIBBLES-1:0]              pc_write_enable,
  output logic                               pc_enable,
  output logic [NIB_W-1:0]                   pc_word,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_count,
  output logic                               overflow,
  output logic                               underflow
);
  localparam int PC_W = NIB_W * PC_NIBBLES;
  logic [PC_W-1:0] pc, pc_d, top;
  logic carry, carry_d, stack_cyc, load_cyc, push, pop, clear;
  logic [NIB_W:0] sum;
  logic [NIB_W-1:0] pc_next;
  logic [PC_NIBBLES-1:0] we_low;
  assign pc_enable = cycle < CYCLE_W'(PC_NIBBLES);
  assign stack_cyc = cycle == CYCLE_W'(PC_NIBBLES);
  assign load_cyc = cycle > CYCLE_W'(PC_NIBBLES);
  always_comb begin
    pc_word = '0;
    for (int i = 0; i < PC_NIBBLES; i++) if (cycle == CYCLE_W'(i)) pc_word = pc[NIB_W*i +: NIB_W];
  end
  // Cycle 0 seeds the +1; later nibbles add the carry left by the previous cycle.
  assign sum = {1'b0, pc_word} + (cycle == '0 ? (NIB_W + 1)'(1) : (NIB_W + 1)'(carry));
  assign pc_next = pc_next_sel == PC_FROM_DATA ? data : pc_next_sel == PC_FROM_REG ? regval : '0;
  assign we_low = pc_write_enable & (-pc_write_enable);
  assign push = !halt && stack_cyc && stack_op == STACK_PUSH;
  assign pop = !halt && stack_cyc && stack_op == STACK_POP;
  assign clear = !halt && stack_cyc && stack_op == STACK_CLR;
  always_comb begin
    pc_d = pc;
    carry_d = carry;
    if (pc_enable) begin
      carry_d = sum[NIB_W];
      for (int i = 0; i < PC_NIBBLES; i++) if (cycle == CYCLE_W'(i)) pc_d[NIB_W*i +: NIB_W] = sum[NIB_W-1:0];
    end else if (pop && stack_count != '0) pc_d = top;
    else if (load_cyc)
      for (int i = 0; i < PC_NIBBLES; i++) if (we_low[i]) pc_d[NIB_W*i +: NIB_W] = pc_next;
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      pc <= '0;
      carry <= 1'b0;
    end else if (!halt) begin
      pc <= pc_d;
      carry <= carry_d;
    end
  return_stack #(.DEPTH(STACK_DEPTH), .W(PC_W)) u_stack (
    .clock(clock),
    .reset(reset),
    .push(push),
    .pop(pop),
    .clear(clear),
    .push_data(pc),
    .top(top),
    .count(stack_count),
    .overflow(overflow),
    .underflow(underflow)
  );
endmodule

// File: tb/tb_pc_stack_gen.sv
// tb_pc_stack_gen: directed stimulus with a fetch-nibble scoreboard and direct status checks.
module tb_pc_stack_gen;
  import pc_stack_gen_pkg::*;
  localparam int N = 3;
  localparam int D = 3;
  localparam int CW = 3;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic halt = 1'b0;
  logic [CW-1:0] cycle = 3'd4;
  logic [1:0] stack_op = 2'd0;
  logic [3:0] regval = 4'd0;
  logic [3:0] data = 4'd0;
  logic [1:0] pc_next_sel = 2'd0;
  logic [N-1:0] pc_write_enable = '0;
  logic pc_enable, overflow, underflow;
  logic [3:0] pc_word;
  logic [1:0] stack_count;
  logic [3:0] exp_q[$];
  logic [3:0] mon_e;
  int n_checks = 0;
  int n_fail = 0;

  pc_stack_gen #(.PC_NIBBLES(N), .STACK_DEPTH(D), .CYCLE_W(CW)) dut (
    .clock(clock), .reset(reset), .halt(halt), .cycle(cycle), .stack_op(stack_op),
    .regval(regval), .data(data), .pc_next_sel(pc_next_sel), .pc_write_enable(pc_write_enable),
    .pc_enable(pc_enable), .pc_word(pc_word), .stack_count(stack_count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clock)
    if (reset && pc_enable) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL pc_word: unexpected nibble %0h with empty scoreboard", pc_word);
      end else begin
        mon_e = exp_q.pop_front();
        check("pc_word", int'(pc_word), int'(mon_e));
      end
    end

  task automatic fetch(input logic [11:0] exp);
    for (int k = 0; k < N; k++) begin
      cycle = CW'(k);
      exp_q.push_back(exp[4*k +: 4]);
      @(posedge clock);
      #1;
    end
    cycle = 3'd4;
  endtask

  task automatic stack(input logic [1:0] op);
    cycle = 3'd3;
    stack_op = op;
    @(negedge clock);
    check("stack_cycle_enable", int'(pc_enable), 0);
    check("stack_cycle_word", int'(pc_word), 0);
    @(posedge clock);
    #1;
    stack_op = STACK_NOP;
    cycle = 3'd4;
  endtask

  task automatic load(input logic [3:0] v, input logic [1:0] sel, input logic [N-1:0] we);
    cycle = 3'd4;
    data = sel == PC_FROM_DATA ? v : ~v;
    regval = sel == PC_FROM_REG ? v : ~v;
    pc_next_sel = sel;
    pc_write_enable = we;
    @(posedge clock);
    #1;
    pc_write_enable = '0;
  endtask

  task automatic status(input string name, input int cnt, input int ov, input int un);
    check({name, "_count"}, int'(stack_count), cnt);
    check({name, "_overflow"}, int'(overflow), ov);
    check({name, "_underflow"}, int'(underflow), un);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    #12;
    status("reset", 0, 0, 0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    // increment from reset; the 17th fetch shows 0x010
    for (int i = 0; i <= 16; i++) fetch(12'(i));
    // wrap from all-ones
    load(4'hF, PC_FROM_DATA, 3'b001);
    load(4'hF, PC_FROM_DATA, 3'b010);
    load(4'hF, PC_FROM_DATA, 3'b100);
    fetch(12'hFFF);
    fetch(12'h000);
    // load sources, unknown select, lowest-bit priority, no-enable hold
    load(4'h9, 2'd2, 3'b111);
    load(4'h1, PC_FROM_REG, 3'b100);
    load(4'h2, PC_FROM_DATA, 3'b110);
    load(4'h3, PC_FROM_REG, 3'b001);
    load(4'h5, PC_FROM_DATA, 3'b000);
    pc_write_enable = 3'b111;
    data = 4'h9;
    stack_op = STACK_PUSH;
    fetch(12'h123);
    pc_write_enable = '0;
    stack_op = STACK_NOP;
    status("ignored_ops", 0, 0, 0);
    stack(STACK_PUSH);
    load(4'h4, PC_FROM_DATA, 3'b100);
    load(4'h5, PC_FROM_DATA, 3'b010);
    load(4'h6, PC_FROM_DATA, 3'b001);
    fetch(12'h456);
    status("call", 1, 0, 0);
    stack(STACK_POP);
    fetch(12'h124);
    status("return", 0, 0, 0);
    // overflow ring and underflow
    load(4'h0, PC_FROM_DATA, 3'b001);
    load(4'h0, PC_FROM_DATA, 3'b010);
    load(4'h0, PC_FROM_DATA, 3'b100);
    fetch(12'h000); stack(STACK_PUSH);
    fetch(12'h001); stack(STACK_PUSH);
    fetch(12'h002); stack(STACK_PUSH);
    fetch(12'h003); stack(STACK_PUSH);
    status("overflow", 3, 1, 0);
    stack(STACK_POP); fetch(12'h004);
    status("pop1", 2, 1, 0);
    stack(STACK_POP); fetch(12'h003);
    stack(STACK_POP); fetch(12'h002);
    status("pop3", 0, 1, 0);
    stack(STACK_POP); fetch(12'h003);
    status("underflow", 0, 1, 1);
    stack(STACK_CLR);
    status("clear", 0, 0, 0);
    // halt freezes everything
    halt = 1'b1;
    fetch(12'h004);
    stack(STACK_PUSH);
    load(4'h7, PC_FROM_DATA, 3'b111);
    halt = 1'b0;
    status("halt", 0, 0, 0);
    fetch(12'h004);
    // async reset mid-ripple
    load(4'h0, PC_FROM_DATA, 3'b100);
    load(4'hF, PC_FROM_DATA, 3'b010);
    load(4'hF, PC_FROM_DATA, 3'b001);
    stack(STACK_PUSH);
    status("pre_reset", 1, 0, 0);
    cycle = 3'd0;
    exp_q.push_back(4'hF);
    @(posedge clock);
    #1;
    cycle = 3'd1;
    exp_q.push_back(4'hF);
    @(negedge clock);
    #1;
    reset = 1'b0;
    #1;
    status("async_reset", 0, 0, 0);
    check("async_reset_nib1", int'(pc_word), 0);
    cycle = 3'd0;
    #1;
    check("async_reset_nib0", int'(pc_word), 0);
    cycle = 3'd2;
    #1;
    check("async_reset_nib2", int'(pc_word), 0);
    cycle = 3'd4;
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    fetch(12'h000);
    repeat (2) @(posedge clock);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pc_stack_gen.md
Name: pc_stack_gen

Overview:
Parametrised successor to the 8-bit nibble-serial program counter. It holds a PC of PC_NIBBLES nibbles and a STACK_DEPTH-entry return-address stack for call/return. The PC is presented one nibble per fetch cycle, and each nibble is incremented with a carry rippled across cycles. The block sits beside the instruction decoder, which supplies the cycle index, stack op, write enables and load data.

Parameters:
PC_NIBBLES, 3, number of 4-bit PC nibbles (PC width = 4*PC_NIBBLES); range 2..6.
STACK_DEPTH, 3, number of return-address entries; range 1..8.
CYCLE_W, 3, width of the cycle index; 2**CYCLE_W must be greater than PC_NIBBLES+1.

Ports:
clock  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
halt  input  1  when high, freezes all state (PC, carry, stack, flags).
cycle  input  CYCLE_W  instruction cycle index from the sequencer.
stack_op  input  2  0=NOP, 1=PUSH, 2=POP, 3=CLEAR_FLAGS.
regval  input  4  register-file nibble.
data  input  4  bus data nibble.
pc_next_sel  input  2  load source: PC_FROM_DATA or PC_FROM_REG.
pc_write_enable  input  PC_NIBBLES  one bit per PC nibble.
pc_enable  output  1  high while a PC nibble is driven.
pc_word  output  4  current PC nibble.
stack_count  output  clog2(STACK_DEPTH+1)  number of valid stack entries.
overflow  output  1  sticky: a PUSH occurred while the stack was full.
underflow  output  1  sticky: a POP occurred while the stack was empty.

Behaviour:
- Reset (reset=0, asynchronous): PC=0, carry=0, stack pointer=0, stack_count=0, overflow=0, underflow=0. Stack entry contents are don't-care. All state changes below apply only when reset=1 and halt=0.
- Fetch cycles, k = 0..PC_NIBBLES-1:
  - pc_word = PC nibble k; pc_enable=1.
  - Cycle 0: {carry, nib0} <= nib0 + 1.
  - Cycle k>0: {carry, nibk} <= nibk + carry.
  - Carry out of the top nibble is discarded, so the PC wraps from all-ones to 0.
  - Outputs are combinational on cycle and reflect the pre-edge PC.
- Stack cycle, cycle == PC_NIBBLES:
  - pc_enable=0, pc_word=0.
  - stack_op is sampled only in this cycle and ignored in all others.
  - PUSH: the already-incremented PC (the return address) is written to stack[sp]; sp <= (sp+1) mod STACK_DEPTH; stack_count <= min(count+1, STACK_DEPTH).
  - PUSH when count==STACK_DEPTH: overwrites the oldest entry (ring behaviour); count stays saturated; overflow <= 1.
  - POP when count>0: PC <= stack[(sp-1) mod STACK_DEPTH]; sp decrements; count decrements.
  - POP when count==0: PC unchanged; sp unchanged; underflow <= 1.
  - CLEAR_FLAGS: overflow <= 0, underflow <= 0; no other effect.
- Load cycles, cycle > PC_NIBBLES:
  - pc_enable=0, pc_word=0.
  - If any pc_write_enable bit is set, only the lowest set bit j is honoured: nibble j <= pc_next.
  - pc_next = data when pc_next_sel==PC_FROM_DATA, regval when PC_FROM_REG; other encodings write 0.
  - If no bit is set, the PC holds.
  - A PUSH followed by load cycles implements a call: the return address is saved before the target is written.
- pc_write_enable is ignored in fetch cycles and the stack cycle.
- halt=1: all registers hold. Outputs still decode from cycle.
- Reset mid-operation: everything clears immediately. A partially rippled increment is abandoned.

Decomposition:
- Shared package/include holds:
  - PC_FROM_DATA=0, PC_FROM_REG=1.
  - STACK_NOP, STACK_PUSH, STACK_POP, STACK_CLR encodings.
  - The nibble width constant 4.
- One sub-module, return_stack:
  - Parametrised storage array with sp and count.
  - push/pop strobes, overflow/underflow detection, top-of-stack read.
- pc_stack_gen holds the PC, the carry, the cycle decode and the load mux.

Test Plan:
1. Reset low then release; run cycles 0..2 for 17 instructions with defaults -> pc_word sequence on the 17th fetch is 0,1,0 (PC=0x010), pc_enable=1 in cycles 0..2 only.
2. PC preloaded to 0xFFF via load cycles (data=F, enables 001,010,100) -> next fetch outputs F,F,F; the following fetch outputs 0,0,0 (wrap, carry discarded).
3. At PC=0x123: PUSH in cycle 3, then load 0x4,0x5,0x6 -> next fetch outputs 6,5,4 and stack_count=1. Then POP -> following fetch outputs 4,2,1 (PC=0x124).
4. Four PUSHes with STACK_DEPTH=3 of return addresses 0x001,0x002,0x003,0x004 -> overflow=1, count=3. Three POPs return 0x004, 0x003, 0x002. A fourth POP leaves PC unchanged and sets underflow=1. CLEAR_FLAGS then clears both flags.
5. halt=1 across a full instruction with PUSH and write enables asserted -> PC, count and flags unchanged; pc_word still tracks cycle.
6. Assert reset mid-ripple at cycle 1 with PC=0x0FF -> PC=0 and count=0 immediately, before the next clock edge.
